dmem_arbiter: RTL
=================

# dmem_arbiter

Arbitrates the single-port data memory between the CPU datapath's load/store port and a debug/loader port. Requests are latched, sequenced through an issue/wait/acknowledge state machine, and the CPU gets a stall signal while its access is pending. The block sits between the CPU's ALU-address/store-data outputs and the data memory array, replacing the direct CPU-to-memory connection.

## Interface
Parameters:
- ADDR_W, 32, byte address width on all ports
- DATA_W, 32, data width on all ports
- MEM_LAT, 1, memory read latency in cycles after the issue cycle; legal range 1..7

Ports:
- clock  in  1  single clock; all state changes on its rising edge
- reset  in  1  asynchronous, active-low reset
- cpu_req  in  1  CPU access request; held high until cpu_ack
- cpu_we  in  1  1 = store, 0 = load
- cpu_addr  in  ADDR_W  CPU byte address
- cpu_wdata  in  DATA_W  CPU store data
- cpu_rdata  out  DATA_W  CPU load data; valid while cpu_ack = 1
- cpu_ack  out  1  one-cycle completion pulse
- cpu_stall  out  1  cpu_req & ~cpu_ack (combinational)
- dbg_req, dbg_we, dbg_addr, dbg_wdata  in  1/1/ADDR_W/DATA_W  debug port, same rules as CPU port
- dbg_rdata  out  DATA_W  debug load data; valid while dbg_ack = 1
- dbg_ack  out  1  one-cycle completion pulse
- mem_en  out  1  memory access strobe, high for exactly the issue cycle
- mem_we  out  1  memory write enable, qualified by mem_en
- mem_addr  out  ADDR_W  latched address of the granted request
- mem_wdata  out  DATA_W  latched store data of the granted request
- mem_rdata  in  DATA_W  memory read data
- owner  out  1  0 = CPU, 1 = debug; owner of the current or last transaction

## Operation
- States: IDLE, ISSUE, WAIT, ACK.
- IDLE: if any req is high, choose a winner (see Configuration). Latch its we/addr/wdata and set owner. Go to ISSUE. Otherwise stay.
- ISSUE: mem_en = 1, with mem_we/mem_addr/mem_wdata taken from the latched values. Load lat_cnt = MEM_LAT. Go to WAIT.
- WAIT: decrement lat_cnt each cycle. In the cycle with lat_cnt = 1:
  - for a load, capture mem_rdata into the owner's rdata register;
  - go to ACK.
- ACK: assert the owner's ack for one cycle. Return to IDLE.
- Stores never update rdata registers. Each rdata register holds its last load value until the next load by the same owner.
- A req still high in the IDLE cycle after ACK is a new transaction. Requesters drop req during ACK if they have no further access.
- The non-granted requester keeps req high and is served after the current transaction. No request is ever dropped.
- Request inputs are sampled only in IDLE. Changes during ISSUE/WAIT/ACK are ignored.

## Timing
- Reset values:
  - state = IDLE, owner = 1, lat_cnt = 0;
  - mem_en = mem_we = 0, mem_addr = mem_wdata = 0;
  - cpu_rdata = dbg_rdata = 0, cpu_ack = dbg_ack = 0.
- Latency: req sampled high in IDLE at cycle 0 → ISSUE at cycle 1 → ack at cycle 2 + MEM_LAT (3 for MEM_LAT = 1).
- Throughput: one transaction per 3 + MEM_LAT cycles.
- cpu_stall is high from the first cycle of cpu_req through the cycle before cpu_ack. It is 0 in the ack cycle.
- Simultaneous requests in IDLE: exactly one grant; the loser waits a full transaction.
- Reset asserted mid-transaction: immediate return to reset values. The in-flight access is abandoned (a store may already have been written), no ack is issued, and requesters must reissue.
- MEM_LAT outside 1..7 is illegal; the implementation stops elaboration with an error.

## Configuration
- DMEM_ARB_RR_EN defined: round-robin arbitration. On a tie, the port that did not own the last transaction wins. Because owner resets to 1, the CPU wins the first tie after reset.
- DMEM_ARB_RR_EN undefined: fixed priority, debug port always wins a tie.
- Single requests behave identically in both builds.

## Test plan
- CPU load alone, MEM_LAT = 1: memory holds 0xDEADBEEF at address 0x10; cpu_req at cycle 0 → mem_en at cycle 1 with mem_addr = 0x10, cpu_ack with cpu_rdata = 0xDEADBEEF at cycle 3, cpu_stall high for cycles 0–2.
- Debug store then CPU load, MEM_LAT = 3: dbg writes 0x12345678 to 0x20, then CPU loads 0x20 → dbg_ack at cycle 5, CPU load returns 0x12345678, and cpu_rdata is unchanged by the store.
- Simultaneous requests, fixed priority: both reqs high at cycle 0 → dbg_ack at cycle 3, cpu_ack at cycle 7 (MEM_LAT = 1), owner 1 then 0.
- Repeated ties with DMEM_ARB_RR_EN defined → grants alternate CPU, debug, CPU, debug; neither port waits more than one transaction.
- Reset asserted in the WAIT cycle → mem_en, acks and rdata go to 0 immediately; no ack pulse; state is IDLE after release; a reissued request completes normally.
- Back-to-back CPU loads with req held high through ACK → second mem_en exactly 4 cycles after the first (MEM_LAT = 1).

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the CPU load/store
// port and the debug/loader port. Each access is latched in IDLE, then steps
// through ISSUE (one-cycle memory strobe), WAIT (MEM_LAT cycles) and ACK
// (one-cycle completion pulse to the owning port).
// Build option: define DMEM_ARB_RR_EN for round-robin tie breaking; without
// it the debug port always wins a tie.
module dmem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              owner
);

  if (MEM_LAT < 1 || MEM_LAT > 7) begin : g_bad_mem_lat
    $error("dmem_arbiter: MEM_LAT must be in the range 1..7");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } state_t;

  localparam logic [2:0] LAT_INIT = 3'(MEM_LAT);

  state_t            state;
  state_t            state_nxt;
  logic [2:0]        lat_cnt;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic              any_req;
  logic              grant_dbg;
  logic              rd_capture;

  // Arbitration: a lone request always wins; a tie is broken by the build option.
  always_comb begin
    any_req = cpu_req | dbg_req;
`ifdef DMEM_ARB_RR_EN
    if (cpu_req && dbg_req) grant_dbg = ~owner;
    else                    grant_dbg = dbg_req;
`else
    grant_dbg = dbg_req;
`endif
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and strobe decode; strobes come straight from the state so a
  // reset drops them in the same instant the state returns to IDLE.
  always_comb begin
    state_nxt = state;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    cpu_ack   = 1'b0;
    dbg_ack   = 1'b0;
    case (state)
      IDLE:  if (any_req) state_nxt = ISSUE;
      ISSUE: begin
        mem_en    = 1'b1;
        mem_we    = lat_we;
        state_nxt = WAIT;
      end
      WAIT:  if (lat_cnt <= 3'd1) state_nxt = ACK;
      ACK:   begin
        cpu_ack   = ~owner;
        dbg_ack   = owner;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Read data is taken in the last WAIT cycle, only for loads.
  assign rd_capture = (state == WAIT) && (lat_cnt <= 3'd1) && !lat_we;

  // Request latch, latency counter, owner and per-port read-data registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      owner     <= 1'b1;
      lat_cnt   <= 3'd0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      cpu_rdata <= '0;
      dbg_rdata <= '0;
    end else begin
      case (state)
        IDLE: if (any_req) begin
          owner     <= grant_dbg;
          lat_we    <= grant_dbg ? dbg_we    : cpu_we;
          lat_addr  <= grant_dbg ? dbg_addr  : cpu_addr;
          lat_wdata <= grant_dbg ? dbg_wdata : cpu_wdata;
        end
        ISSUE: lat_cnt <= LAT_INIT;
        WAIT:  lat_cnt <= lat_cnt - 3'd1;
        default: ;
      endcase
      if (rd_capture) begin
        if (owner) dbg_rdata <= mem_rdata;
        else       cpu_rdata <= mem_rdata;
      end
    end
  end

  assign mem_addr  = lat_addr;
  assign mem_wdata = lat_wdata;
  assign cpu_stall = cpu_req & ~cpu_ack;

endmodule
